// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder datapath.
// Mode encoding for the sub input and the per-stage chunk width.
// No logic, no state: compile before any module that imports it.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Bits handled by one pipeline stage; degenerate stage counts fall back to
  // the full width so the caller's elaboration check can report them cleanly.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1) begin
      return width;
    end
    return width / stages;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit ripple-carry slice of the pipelined adder.
// Purely combinational, zero latency.
// No flow control; the enclosing pipeline decides when results are captured.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  // Bit-serial ripple: each bit's carry feeds the next; c_msb is the carry
  // entering the top bit, which the last stage needs for signed overflow.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipe_gen_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage.
// Latency STAGES non-stalled cycles, throughput one op per cycle.
// stall freezes every register and masks out_valid; nothing is dropped.
module pipe_gen_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NST   = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = chunk_width(WIDTH, NST);
  localparam int LAST  = NST - 1;

  if ((STAGES < 1) || ((WIDTH % NST) != 0)) begin : g_bad_params
    $error("pipe_gen_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Stage k registers: valid, carry out of chunk k, skewed operands (a and
  // the already-conditioned b) and the sum with chunks 0..k filled in.
  // The last stage's sum/carry registers double as the output registers.
  logic [NST-1:0]   v_q, v_d;
  logic [NST-1:0]   c_q, c_d;
  logic [NST-1:0]   msb_d;
  logic             m_q;
  logic [WIDTH-1:0] a_q  [NST];
  logic [WIDTH-1:0] a_d  [NST];
  logic [WIDTH-1:0] bx_q [NST];
  logic [WIDTH-1:0] bx_d [NST];
  logic [WIDTH-1:0] s_q  [NST];
  logic [WIDTH-1:0] s_d  [NST];

  for (genvar k = 0; k < NST; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_bx, src_s, s_new;
    logic             src_c, src_v;
    logic [CHUNK-1:0] ck_sum;
    logic             ck_cout, ck_msb;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1: invert b once here and force the carry.
      assign src_a  = a;
      assign src_bx = (sub == SUB) ? ~b : b;
      assign src_s  = '0;
      assign src_c  = (sub == SUB) ? 1'b1 : c_in;
      assign src_v  = in_valid;
    end else begin : g_body
      assign src_a  = a_q[k-1];
      assign src_bx = bx_q[k-1];
      assign src_s  = s_q[k-1];
      assign src_c  = c_q[k-1];
      assign src_v  = v_q[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (src_a[k*CHUNK +: CHUNK]),
      .b     (src_bx[k*CHUNK +: CHUNK]),
      .cin   (src_c),
      .sum   (ck_sum),
      .cout  (ck_cout),
      .c_msb (ck_msb)
    );

    // Drop this stage's chunk into the partially built sum.
    always_comb begin
      s_new                    = src_s;
      s_new[k*CHUNK +: CHUNK]  = ck_sum;
    end

    assign v_d[k]   = src_v;
    assign c_d[k]   = ck_cout;
    assign msb_d[k] = ck_msb;
    assign a_d[k]   = src_a;
    assign bx_d[k]  = src_bx;
    assign s_d[k]   = s_new;
  end

  // Advance the whole pipe unless stalled; the output stage only loads on a
  // valid result so sum/c_out/ovf hold the last answer across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= 1'b0;
      for (int k = 0; k < NST; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
      end
    end else if (!stall) begin
      v_q <= v_d;
      for (int k = 0; k < NST; k++) begin
        a_q[k]  <= a_d[k];
        bx_q[k] <= bx_d[k];
      end
      for (int k = 0; k < LAST; k++) begin
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      if (v_d[LAST]) begin
        s_q[LAST] <= s_d[LAST];
        c_q[LAST] <= c_d[LAST];
        m_q       <= msb_d[LAST];
      end
    end
  end

  // The last stage's skewed operands and the inner stages' top-bit carries
  // have no consumer; fold them into a sink so they are visibly intentional.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], bx_q[LAST], msb_d};

  // A held result is only offered to the consumer on a cycle it can move.
  assign out_valid = v_q[LAST] & ~stall;
  assign sum       = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign ovf       = m_q ^ c_q[LAST];

endmodule

// File: tb/tb_pipe_gen_adder.sv
module tb_pipe_gen_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } res_t;

  localparam int NDUT = 3;
  localparam int WD [NDUT] = '{16, 5, 5};
  localparam int SD [NDUT] = '{4, 1, 5};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;
  logic        stall = 1'b0;

  logic        ov [NDUT];
  logic        co [NDUT];
  logic        of [NDUT];
  logic [15:0] s16;
  logic [4:0]  s5a, s5b;
  logic [15:0] obs_s [NDUT];

  assign obs_s[0] = s16;
  assign obs_s[1] = {11'b0, s5a};
  assign obs_s[2] = {11'b0, s5b};

  pipe_gen_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .stall(stall), .out_valid(ov[0]), .sum(s16), .c_out(co[0]), .ovf(of[0])
  );
  pipe_gen_adder #(.WIDTH(5), .STAGES(1)) u_dut5s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a[4:0]), .b(b[4:0]), .c_in(c_in),
    .sub(sub), .stall(stall), .out_valid(ov[1]), .sum(s5a), .c_out(co[1]), .ovf(of[1])
  );
  pipe_gen_adder #(.WIDTH(5), .STAGES(5)) u_dut5s5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a[4:0]), .b(b[4:0]), .c_in(c_in),
    .sub(sub), .stall(stall), .out_valid(ov[2]), .sum(s5b), .c_out(co[2]), .ovf(of[2])
  );

  always #5 clk = ~clk;

  // Reference model: per-DUT FIFO of expected results tagged with the count
  // of non-stalled, non-reset edges at which each must appear.
  res_t mb [NDUT][16];
  int   hd [NDUT];
  int   tl [NDUT];
  res_t held [NDUT];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic res_t ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input logic ci, input logic sbt);
    res_t   r;
    longint mask, half, ua, ub, sa, sbv, exact;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sbv  = (ub >= half) ? ub - (mask + 1) : ub;
    if (sbt) begin
      exact  = sa - sbv;
      r.cout = (ua >= ub);
    end else begin
      exact  = sa + sbv + longint'(ci);
      r.cout = ((ua + ub + longint'(ci)) > mask);
    end
    r.sum = 16'(exact & mask);
    r.ovf = (exact < -half) || (exact > half - 1);
    r.due = 0;
    return r;
  endfunction

  function automatic void exp_out(input int d, output logic ev, output logic [15:0] es,
                                  output logic ec, output logic eo);
    if (hd[d] != tl[d] && mb[d][hd[d] % 16].due == cyc) begin
      ev = !stall;
      es = mb[d][hd[d] % 16].sum;
      ec = mb[d][hd[d] % 16].cout;
      eo = mb[d][hd[d] % 16].ovf;
    end else begin
      ev = 1'b0;
      es = held[d].sum;
      ec = held[d].cout;
      eo = held[d].ovf;
    end
  endfunction

  // Clock one edge (applying the inputs currently driven), update the model,
  // then drive the next cycle's inputs; outputs are sampled afterwards.
  task automatic tick(input logic r, input logic v, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sbt, input logic stl);
    res_t e;
    @(posedge clk);
    if (reset) begin
      for (int d = 0; d < NDUT; d++) begin
        hd[d] = 0;
        tl[d] = 0;
        held[d] = '{16'h0, 1'b0, 1'b0, 0};
      end
    end else if (!stall) begin
      for (int d = 0; d < NDUT; d++) begin
        if (hd[d] != tl[d] && mb[d][hd[d] % 16].due == cyc) begin
          held[d] = mb[d][hd[d] % 16];
          hd[d]++;
        end
      end
      cyc++;
      if (in_valid) begin
        for (int d = 0; d < NDUT; d++) begin
          e = ref_op(WD[d], a, b, c_in, sub);
          e.due = cyc + SD[d] - 1;
          mb[d][tl[d] % 16] = e;
          tl[d]++;
        end
      end
    end
    @(negedge clk);
    reset = r; in_valid = v; a = av; b = bv; c_in = ci; sub = sbt; stall = stl;
    #1;
  endtask

  task automatic test_reset();
    // Reset dominates in_valid and stall.
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, 1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0, i < 2);
      for (int d = 0; d < NDUT; d++) begin
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== 19'h0) begin
          miscompares++;
          $display("FAIL reset dut%0d: got v=%b s=%h c=%b o=%b, want all zero",
                   d, ov[d], obs_s[d], co[d], of[d]);
        end
      end
    end
  endtask

  task automatic test_carry_ripple();
    logic ev, ec, eo;
    logic [15:0] es;
    tick(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL carry dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
      if (i == 4) begin
        vectors++;
        if ({ov[0], s16, co[0], of[0]} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL carry_const: got v=%b s=%h c=%b o=%b, want v=1 s=0000 c=1 o=0",
                   ov[0], s16, co[0], of[0]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic ev, ec, eo;
    logic [15:0] es;
    tick(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL ovf dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if ({ov[0], s16, co[0], of[0]} !== ((i == 3) ? {1'b1, 16'h8000, 1'b0, 1'b1}
                                                     : {1'b1, 16'hFFFE, 1'b0, 1'b0})) begin
          miscompares++;
          $display("FAIL ovf_const step%0d: got v=%b s=%h c=%b o=%b, want %s",
                   i, ov[0], s16, co[0], of[0], (i == 3) ? "v=1 s=8000 c=0 o=1" : "v=1 s=FFFE c=0 o=0");
        end
      end
    end
  endtask

  task automatic test_stall();
    logic ev, ec, eo;
    logic [15:0] es;
    int pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 4)
        tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      else if (i < 6)
        tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
      else
        tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      if (ov[0] === 1'b1) pulses++;
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL stall dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
    end
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL stall_count: got %0d results, want 4", pulses);
    end
  endtask

  task automatic test_reset_flush();
    logic ev, ec, eo;
    logic [15:0] es;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 3)
        tick(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      else if (i == 3)
        tick(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      else if (i == 4)
        tick(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
      else
        tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      if (ov[0] === 1'b1) pulses++;
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL flush dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL flush_count: got %0d results, want 1", pulses);
    end
  endtask

  task automatic test_random();
    logic ev, ec, eo;
    logic [15:0] es;
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(3) == 0));
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL random dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
    end
  endtask

  task automatic test_exhaustive5();
    logic ev, ec, eo;
    logic [15:0] es;
    for (int n = 0; n < 4096 + 8; n++) begin
      if (n < 4096)
        tick(1'b0, 1'b1, {11'($urandom), 5'(n % 32)}, {11'($urandom), 5'((n / 32) % 32)},
             1'((n / 1024) % 2), 1'(n / 2048), 1'b0);
      else
        tick(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        exp_out(d, ev, es, ec, eo);
        vectors++;
        if ({ov[d], obs_s[d], co[d], of[d]} !== {ev, es, ec, eo}) begin
          miscompares++;
          $display("FAIL exh5 dut%0d t=%0t: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                   d, $time, ov[d], obs_s[d], co[d], of[d], ev, es, ec, eo);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      hd[d] = 0;
      tl[d] = 0;
      held[d] = '{16'h0, 1'b0, 1'b0, 0};
    end
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_stall();
    test_reset_flush();
    test_random();
    test_exhaustive5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
